dmem_core_arbiter: RTL
======================

Name: dmem_core_arbiter

Overview:
- Upstream stage of the shared data-memory atomic unit.
- Accepts per-core D-memory requests (plain loads/stores, AMO, LR/SC) from N cores and buffers one request per core.
- Grants one core at a time by round-robin and presents that request, with a one-hot core ID, to the atomic unit's core-side port.
- Holds the request stable until completion, then returns done and read data to the originating core.

Parameters:
- N, 2, number of cores; legal range 1..4.
- XLEN, 32, address width.
- CLSIZE, 256, cache-line width in bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- P_strobe_i  in  N  per-core request pulse, one cycle
- P_addr_i  in  N*XLEN  per-core address; core k occupies slice [k*XLEN +: XLEN]
- P_rw_i  in  N  per-core 1 = write
- P_data_i  in  N*CLSIZE  per-core write line
- P_is_amo_i  in  N  per-core atomic flag
- P_amo_type_i  in  N*5  per-core AMO funct5
- P_done_o  out  N  per-core completion pulse
- P_data_o  out  CLSIZE  read line, shared by all cores; valid with P_done_o
- core_id_o  out  N  one-hot granted core
- core_strobe_o  out  1  request pulse to atomic unit
- core_addr_o  out  XLEN  held address
- core_rw_o  out  1  held rw
- core_data_o  out  CLSIZE  held write data
- core_is_amo_o  out  1  held atomic flag
- core_amo_type_o  out  5  held AMO type
- core_done_i  in  1  completion from atomic unit
- core_data_i  in  CLSIZE  read data from atomic unit

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: all outputs 0; pending[] = 0; rr_ptr = 0; state = IDLE.
- Reset mid-transaction drops all pending and in-flight requests and issues no done pulse. The atomic unit shares the same reset.
- Capture: on P_strobe_i[k]=1, latch core k's addr/rw/data/is_amo/amo_type into buffer k and set pending[k] next edge.
  - A strobe while pending[k]=1 is a protocol violation: ignore it and fire an assertion.
  - Exception: a strobe in the same cycle pending[k] is cleared by completion re-arms pending[k]; set wins.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any pending, pick winner g = first pending at or after rr_ptr, cyclically. Load g's buffer into the core_* output registers, set core_id_o = 1<<g, go to ISSUE. Else stay in IDLE.
  - ISSUE: core_strobe_o=1 for exactly this cycle; go to WAIT.
  - WAIT: core_strobe_o=0. core_id_o and all core_* fields stay constant (required for AMO read-modify-write and LR/SC reservation matching). On core_done_i=1:
    - P_done_o[g] <= 1 for one cycle.
    - P_data_o <= core_data_i.
    - pending[g] <= 0.
    - rr_ptr <= (g+1) mod N.
    - go to IDLE.
- A core_done_i seen in IDLE or ISSUE is ignored and fires an assertion.
- core_id_o stays at the last grant while IDLE; it clears to 0 only on reset.
- Latency: strobe in cycle t → pending at t+1 → core_strobe_o in t+2. core_done_i in cycle d → P_done_o in d+1.
- Minimum turnaround between grants: 2 cycles after done (IDLE, then ISSUE).
- Fairness: with all N cores continuously pending, each core is granted once per N transactions.
- N=1: rr_ptr is constant 0; core_id_o = 1 whenever a grant is held.
- Atomicity: arbitration happens only in IDLE, so an AMO's read and write phases are never interleaved with another core's access.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encoding localparams IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2;
  - AMO_TYPE_W=5.
- One natural sub-module: rr_picker. It is combinational; inputs are pending[N] and rr_ptr; outputs are a one-hot grant[N] and a binary index. It is reusable for the I-memory arbiter.

Test Plan:
- Single plain read: core0 strobes addr=0x8000_0040, rw=0; atomic unit answers done 3 cycles after strobe_o with data=0xA5..A5 → core_strobe_o in cycle t+2, core_id_o=2'b01, P_done_o=2'b01 one cycle after done, P_data_o=0xA5..A5.
- Simultaneous strobes from core0 and core1 at reset (rr_ptr=0) → core0 served first; core1 strobe_o issued exactly 2 cycles after core0's done; core_id_o=2'b10; rr_ptr ends at 0.
- Hold stability: core1 AMOADD (type 5'b00000) at 0x100 takes 10 cycles to done while core0 strobes mid-transaction → core_addr_o, core_amo_type_o and core_id_o are unchanged throughout WAIT; core0 is granted only after core1's done.
- Fairness: both cores re-strobe on every done for 20 transactions → grants strictly alternate 01,10,01,...; no core granted twice in a row.
- Reset in WAIT: assert rst_i while core0's request is in flight with core1 pending → next cycle all outputs 0, no P_done_o ever pulses; a fresh core1 strobe after reset is served normally.
- Re-arm on done: core0 strobes again in the same cycle its P_done_o-causing core_done_i arrives → pending[0] stays set and a second transaction issues with the new address.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the D-memory core arbiter and its round-robin picker.
package dmem_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam int AMO_TYPE_W = 5;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_ISSUE = ISSUE,
        S_WAIT  = WAIT
    } arb_state_e;

    // Width of a binary core index; a single core still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_core_arbiter_if.sv
// Bus bundle between N cores, the arbiter and the atomic unit's core-side port.
// master = the arbiter, slave = the environment (cores + atomic unit).
interface dmem_core_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int N      = 2,
    parameter int XLEN   = 32,
    parameter int CLSIZE = 256
);

    logic [N-1:0]            P_strobe_i;
    logic [N*XLEN-1:0]       P_addr_i;
    logic [N-1:0]            P_rw_i;
    logic [N*CLSIZE-1:0]     P_data_i;
    logic [N-1:0]            P_is_amo_i;
    logic [N*AMO_TYPE_W-1:0] P_amo_type_i;
    logic [N-1:0]            P_done_o;
    logic [CLSIZE-1:0]       P_data_o;

    logic [N-1:0]            core_id_o;
    logic                    core_strobe_o;
    logic [XLEN-1:0]         core_addr_o;
    logic                    core_rw_o;
    logic [CLSIZE-1:0]       core_data_o;
    logic                    core_is_amo_o;
    logic [AMO_TYPE_W-1:0]   core_amo_type_o;
    logic                    core_done_i;
    logic [CLSIZE-1:0]       core_data_i;

    modport master (
        input  P_strobe_i, P_addr_i, P_rw_i, P_data_i, P_is_amo_i, P_amo_type_i,
        output P_done_o, P_data_o,
        output core_id_o, core_strobe_o, core_addr_o, core_rw_o, core_data_o,
        output core_is_amo_o, core_amo_type_o,
        input  core_done_i, core_data_i
    );

    modport slave (
        output P_strobe_i, P_addr_i, P_rw_i, P_data_i, P_is_amo_i, P_amo_type_i,
        input  P_done_o, P_data_o,
        input  core_id_o, core_strobe_o, core_addr_o, core_rw_o, core_data_o,
        input  core_is_amo_o, core_amo_type_o,
        output core_done_i, core_data_i
    );

endinterface

// File: rtl/dmem_core_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending requester at or after rr_ptr,
// searching cyclically. Shared with the I-memory arbiter.
module rr_picker
    import dmem_arb_pkg::*;
#(
    parameter int N    = 2,
    parameter int IDXW = idx_width(N)
) (
    input  logic [N-1:0]    pending_i,
    input  logic [IDXW-1:0] rr_ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [IDXW-1:0] idx_o
);

    logic found;
    int   cand;

    // Scan N positions starting at rr_ptr; the first pending one wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(rr_ptr_i) + i) % N;
            if (!found && pending_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/dmem_core_arbiter.sv
// Buffers one D-memory request per core, grants the atomic unit round-robin,
// holds the granted request stable until completion and returns done/data.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no request in flight; pick a winner if any core is pending
//   S_ISSUE | core_strobe_o high for this one cycle
//   S_WAIT  | request held stable on core_*; wait for core_done_i
module dmem_core_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N      = 2,
    parameter int XLEN   = 32,
    parameter int CLSIZE = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dmem_core_arbiter_if.master bus
);

    localparam int IDXW = idx_width(N);

    arb_state_e state_q, state_d;

    logic [N-1:0]    pending_q, pending_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0] gidx_q, gidx_d;

    logic [XLEN-1:0]       addr_buf_q [N];
    logic [XLEN-1:0]       addr_buf_d [N];
    logic [CLSIZE-1:0]     data_buf_q [N];
    logic [CLSIZE-1:0]     data_buf_d [N];
    logic [AMO_TYPE_W-1:0] type_buf_q [N];
    logic [AMO_TYPE_W-1:0] type_buf_d [N];
    logic [N-1:0]          rw_buf_q, rw_buf_d;
    logic [N-1:0]          amo_buf_q, amo_buf_d;

    logic [N-1:0]          core_id_q, core_id_d;
    logic                  core_strobe_q, core_strobe_d;
    logic [XLEN-1:0]       core_addr_q, core_addr_d;
    logic                  core_rw_q, core_rw_d;
    logic [CLSIZE-1:0]     core_data_q, core_data_d;
    logic                  core_is_amo_q, core_is_amo_d;
    logic [AMO_TYPE_W-1:0] core_amo_type_q, core_amo_type_d;
    logic [N-1:0]          p_done_q, p_done_d;
    logic [CLSIZE-1:0]     p_data_q, p_data_d;

    logic [N-1:0]    pick_grant;
    logic [IDXW-1:0] pick_idx;
    logic [N-1:0]    done_clear;

    rr_picker #(.N(N), .IDXW(IDXW)) u_picker (
        .pending_i (pending_q),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (pick_grant),
        .idx_o     (pick_idx)
    );

    // Completion releases exactly the granted core; core_id_q is already one-hot.
    assign done_clear = (state_q == S_WAIT && bus.core_done_i) ? core_id_q : '0;

    // Per-core capture: a fresh strobe is taken when the slot is free or being
    // freed this cycle (re-arm on done); a strobe into a busy slot is dropped.
    always_comb begin
        pending_d  = pending_q;
        addr_buf_d = addr_buf_q;
        data_buf_d = data_buf_q;
        type_buf_d = type_buf_q;
        rw_buf_d   = rw_buf_q;
        amo_buf_d  = amo_buf_q;
        for (int k = 0; k < N; k++) begin
            if (bus.P_strobe_i[k] && (!pending_q[k] || done_clear[k])) begin
                pending_d[k]  = 1'b1;
                addr_buf_d[k] = bus.P_addr_i[k*XLEN +: XLEN];
                data_buf_d[k] = bus.P_data_i[k*CLSIZE +: CLSIZE];
                type_buf_d[k] = bus.P_amo_type_i[k*AMO_TYPE_W +: AMO_TYPE_W];
                rw_buf_d[k]   = bus.P_rw_i[k];
                amo_buf_d[k]  = bus.P_is_amo_i[k];
            end else if (done_clear[k]) begin
                pending_d[k] = 1'b0;
            end
        end
    end

    // Grant/issue/wait sequencing; core_* only change on a new grant so an AMO
    // or LR/SC sees one stable request across its whole lifetime.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        gidx_d          = gidx_q;
        core_id_d       = core_id_q;
        core_strobe_d   = 1'b0;
        core_addr_d     = core_addr_q;
        core_rw_d       = core_rw_q;
        core_data_d     = core_data_q;
        core_is_amo_d   = core_is_amo_q;
        core_amo_type_d = core_amo_type_q;
        p_done_d        = '0;
        p_data_d        = p_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    gidx_d          = pick_idx;
                    core_id_d       = pick_grant;
                    core_addr_d     = addr_buf_q[pick_idx];
                    core_rw_d       = rw_buf_q[pick_idx];
                    core_data_d     = data_buf_q[pick_idx];
                    core_is_amo_d   = amo_buf_q[pick_idx];
                    core_amo_type_d = type_buf_q[pick_idx];
                    core_strobe_d   = 1'b1;
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_done_i) begin
                    p_done_d = core_id_q;
                    p_data_d = bus.core_data_i;
                    rr_ptr_d = (gidx_q == IDXW'(N - 1)) ? '0 : gidx_q + IDXW'(1);
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, buffers and output registers; reset drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            pending_q       <= '0;
            rr_ptr_q        <= '0;
            gidx_q          <= '0;
            rw_buf_q        <= '0;
            amo_buf_q       <= '0;
            for (int k = 0; k < N; k++) begin
                addr_buf_q[k] <= '0;
                data_buf_q[k] <= '0;
                type_buf_q[k] <= '0;
            end
            core_id_q       <= '0;
            core_strobe_q   <= 1'b0;
            core_addr_q     <= '0;
            core_rw_q       <= 1'b0;
            core_data_q     <= '0;
            core_is_amo_q   <= 1'b0;
            core_amo_type_q <= '0;
            p_done_q        <= '0;
            p_data_q        <= '0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            rr_ptr_q        <= rr_ptr_d;
            gidx_q          <= gidx_d;
            rw_buf_q        <= rw_buf_d;
            amo_buf_q       <= amo_buf_d;
            addr_buf_q      <= addr_buf_d;
            data_buf_q      <= data_buf_d;
            type_buf_q      <= type_buf_d;
            core_id_q       <= core_id_d;
            core_strobe_q   <= core_strobe_d;
            core_addr_q     <= core_addr_d;
            core_rw_q       <= core_rw_d;
            core_data_q     <= core_data_d;
            core_is_amo_q   <= core_is_amo_d;
            core_amo_type_q <= core_amo_type_d;
            p_done_q        <= p_done_d;
            p_data_q        <= p_data_d;
        end
    end

    assign bus.core_id_o       = core_id_q;
    assign bus.core_strobe_o   = core_strobe_q;
    assign bus.core_addr_o     = core_addr_q;
    assign bus.core_rw_o       = core_rw_q;
    assign bus.core_data_o     = core_data_q;
    assign bus.core_is_amo_o   = core_is_amo_q;
    assign bus.core_amo_type_o = core_amo_type_q;
    assign bus.P_done_o        = p_done_q;
    assign bus.P_data_o        = p_data_q;

    // Protocol checks: no re-strobe into a busy slot, no completion outside WAIT.
    a_no_busy_strobe: assert property (@(posedge clk_i) disable iff (rst_i)
        ((bus.P_strobe_i & pending_q & ~done_clear) == '0));
    a_done_only_in_wait: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.core_done_i |-> (state_q == S_WAIT)));

endmodule
